// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: switch sync/debounce, step prescaler and IDLE/LOAD/RUN/HOLD pattern FSM.
// Optional macro LED_SEQ_BOUNCE_EN turns mode 3 into a bounce pattern instead of rotate-right.
module led_pattern_sequencer #(
  parameter int unsigned DIV_MAX    = 50000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LED_EN,
  input  logic       SW1,
  input  logic       SW2,
  output logic [7:0] LED_OUT,
  output logic       step_tick,
  output logic [1:0] mode
);

  localparam int unsigned PRESC_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t             state, state_d;
  logic [1:0]         sync1, raw, raw_prev;
  logic [DEB_W-1:0]   deb_cnt, deb_cnt_inc;
  logic               stable, mode_upd;
  logic [PRESC_W-1:0] presc, presc_d;
  logic [7:0]         led_d;
  logic               tick_d;
  logic               presc_end;
`ifdef LED_SEQ_BOUNCE_EN
  logic               dir, dir_d;   // 0 = moving left, 1 = moving right
`endif

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    seed_of = 8'h01;
      2'd1:    seed_of = 8'h05;
      2'd2:    seed_of = 8'hFE;
`ifdef LED_SEQ_BOUNCE_EN
      default: seed_of = 8'h01;
`else
      default: seed_of = 8'h80;
`endif
    endcase
  endfunction

  // Two-flop synchronizer followed by a stability counter on the synchronized pair
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      raw      <= '0;
      raw_prev <= '0;
      deb_cnt  <= '0;
      mode     <= '0;
    end else begin
      sync1    <= {SW1, SW2};
      raw      <= sync1;
      raw_prev <= raw;
      if (mode_upd) begin
        mode    <= raw;
        deb_cnt <= '0;
      end else if (stable && (raw != mode)) begin
        deb_cnt <= deb_cnt_inc;
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign stable      = (raw == raw_prev);
  assign deb_cnt_inc = deb_cnt + DEB_W'(1);
  assign mode_upd    = stable && (raw != mode) && (deb_cnt_inc >= DEB_W'(DEB_CYCLES - 1));
  assign presc_end   = (presc == PRESC_W'(DIV_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Mode updates win over the enable so a new mode always reloads its seed
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (LED_EN) state_d = LOAD;
      LOAD:    state_d = mode_upd ? LOAD : RUN;
      RUN:     if (mode_upd) state_d = LOAD;
               else if (!LED_EN) state_d = HOLD;
      HOLD:    if (mode_upd) state_d = IDLE;
               else if (LED_EN) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d   = LED_OUT;
    presc_d = presc;
    tick_d  = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d   = dir;
`endif
    case (state)
      IDLE: begin
        led_d   = '0;
        presc_d = '0;
      end
      LOAD: begin
        led_d   = seed_of(mode);
        presc_d = '0;
`ifdef LED_SEQ_BOUNCE_EN
        dir_d   = 1'b0;
`endif
      end
      RUN: begin
        if (mode_upd) begin
          presc_d = '0;
        end else if (presc_end) begin
          presc_d = '0;
          tick_d  = 1'b1;
          led_d   = {LED_OUT[6:0], LED_OUT[7]};
          if (mode == 2'd3) begin
`ifdef LED_SEQ_BOUNCE_EN
            if (!dir) begin
              if (LED_OUT == 8'h80) begin
                led_d = 8'h40;
                dir_d = 1'b1;
              end
            end else if (LED_OUT == 8'h01) begin
              dir_d = 1'b0;
            end else begin
              led_d = {LED_OUT[0], LED_OUT[7:1]};
            end
`else
            led_d = {LED_OUT[0], LED_OUT[7:1]};
`endif
          end
        end else begin
          presc_d = presc + PRESC_W'(1);
        end
      end
      HOLD: begin
        if (mode_upd) begin
          led_d   = '0;
          presc_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      LED_OUT   <= '0;
      step_tick <= 1'b0;
      presc     <= '0;
`ifdef LED_SEQ_BOUNCE_EN
      dir       <= 1'b0;
`endif
    end else begin
      LED_OUT   <= led_d;
      step_tick <= tick_d;
      presc     <= presc_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir       <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIV_MAX=4, DEB_CYCLES=3.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       LED_EN;
  logic       SW1;
  logic       SW2;
  logic [7:0] LED_OUT;
  logic       step_tick;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] cur;

`ifdef LED_SEQ_BOUNCE_EN
  localparam int N3 = 15;
  localparam logic [7:0] SEED3 = 8'h01;
  logic [7:0] seq3 [N3] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
  localparam int N3 = 8;
  localparam logic [7:0] SEED3 = 8'h80;
  logic [7:0] seq3 [N3] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
`endif
  logic [7:0] seq0 [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] seq1 [8] = '{8'h0A, 8'h14, 8'h28, 8'h50, 8'hA0, 8'h41, 8'h82, 8'h05};

  led_pattern_sequencer #(.DIV_MAX(4), .DEB_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .LED_EN    (LED_EN),
    .SW1       (SW1),
    .SW2       (SW2),
    .LED_OUT   (LED_OUT),
    .step_tick (step_tick),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  // Advance one clock and check LED_OUT/step_tick at the falling edge
  task automatic cyc_chk(input logic [7:0] el, input logic et, input string tag);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    assert (LED_OUT === el) else begin
      n_fail++;
      $error("FAIL %s led observed=%h expected=%h", tag, LED_OUT, el);
    end
    n_checks++;
    assert (step_tick === et) else begin
      n_fail++;
      $error("FAIL %s tick observed=%b expected=%b", tag, step_tick, et);
    end
  endtask

  task automatic chk_mode(input logic [1:0] em, input string tag);
    n_checks++;
    assert (mode === em) else begin
      n_fail++;
      $error("FAIL %s mode observed=%0d expected=%0d", tag, mode, em);
    end
  endtask

  // One full step from prescaler 0: three quiet cycles then the tick with the new value
  task automatic step_to(input logic [7:0] exp, input string tag);
    for (int i = 0; i < 3; i++) cyc_chk(cur, 1'b0, tag);
    cyc_chk(exp, 1'b1, tag);
    cur = exp;
  endtask

  initial begin
    rst = 1'b1; LED_EN = 1'b1; SW1 = 1'b0; SW2 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc_chk(8'h00, 1'b0, "reset");
      chk_mode(2'd0, "reset");
    end
    rst = 1'b0;
    cyc_chk(8'h00, 1'b0, "load");
    cyc_chk(8'h01, 1'b0, "seed0");
    cur = 8'h01;
    for (int i = 0; i < 8; i++) step_to(seq0[i], "mode0");

    // Two-cycle glitch on SW2 must not change the mode
    SW2 = 1'b1;
    cyc_chk(8'h01, 1'b0, "glitch");
    cyc_chk(8'h01, 1'b0, "glitch");
    SW2 = 1'b0;
    cyc_chk(8'h01, 1'b0, "glitch");
    cyc_chk(8'h02, 1'b1, "glitch");
    cur = 8'h02;
    step_to(8'h04, "glitch");
    step_to(8'h08, "glitch");
    chk_mode(2'd0, "glitch");

    // Hold with prescaler at 2, resume
    cyc_chk(8'h08, 1'b0, "prehold");
    cyc_chk(8'h08, 1'b0, "prehold");
    LED_EN = 1'b0;
    for (int i = 0; i < 10; i++) cyc_chk(8'h08, 1'b0, "hold");
    LED_EN = 1'b1;
    cyc_chk(8'h08, 1'b0, "resume");
    cyc_chk(8'h10, 1'b1, "resume");
    cur = 8'h10;

    // Mode 1
    SW2 = 1'b1;
    cyc_chk(8'h10, 1'b0, "m1_deb");
    chk_mode(2'd0, "m1_e1");
    cyc_chk(8'h10, 1'b0, "m1_deb");
    cyc_chk(8'h10, 1'b0, "m1_deb");
    cyc_chk(8'h20, 1'b1, "m1_deb");
    chk_mode(2'd0, "m1_e4");
    cyc_chk(8'h20, 1'b0, "m1_upd");
    chk_mode(2'd1, "m1_e5");
    cyc_chk(8'h05, 1'b0, "m1_seed");
    cur = 8'h05;
    for (int i = 0; i < 8; i++) step_to(seq1[i], "mode1");

    // Mode 2, with the mode update landing on a pending tick
    for (int i = 0; i < 3; i++) cyc_chk(8'h05, 1'b0, "m2_pre");
    SW1 = 1'b1; SW2 = 1'b0;
    cyc_chk(8'h0A, 1'b1, "m2_deb");
    for (int i = 0; i < 3; i++) cyc_chk(8'h0A, 1'b0, "m2_deb");
    chk_mode(2'd1, "m2_e4");
    cyc_chk(8'h0A, 1'b0, "m2_drop");
    chk_mode(2'd2, "m2_e5");
    cyc_chk(8'hFE, 1'b0, "m2_seed");
    cur = 8'hFE;
    step_to(8'hFD, "mode2");
    step_to(8'hFB, "mode2");
    step_to(8'hF7, "mode2");

    // Mode 3
    SW2 = 1'b1;
    for (int i = 0; i < 3; i++) cyc_chk(8'hF7, 1'b0, "m3_deb");
    cyc_chk(8'hEF, 1'b1, "m3_deb");
    cyc_chk(8'hEF, 1'b0, "m3_upd");
    chk_mode(2'd3, "m3_e5");
    cyc_chk(SEED3, 1'b0, "m3_seed");
    cur = SEED3;
    for (int i = 0; i < N3; i++) step_to(seq3[i], "mode3");

    // Reset mid-run
    rst = 1'b1;
    cyc_chk(8'h00, 1'b0, "midrst");
    chk_mode(2'd0, "midrst");
    cyc_chk(8'h00, 1'b0, "midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
